// File: rtl/camera_pkg.sv
// Shared types and pixel-format helpers for the DVP camera capture front-end.
// Grey conversion weights green twice so the 7-bit sum divided by four stays within 5 bits.
package camera_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        DONE    = 2'd3
    } cam_state_e;

    localparam logic MODE_RGB444 = 1'b0;
    localparam logic MODE_GREY   = 1'b1;

    function automatic logic [11:0] rgb565_to_444(input logic [15:0] px);
        return {px[15:12], px[10:7], px[4:1]};
    endfunction

    function automatic logic [11:0] rgb565_to_grey(input logic [15:0] px);
        logic [6:0] sum_s;
        logic [4:0] y5_s;
        sum_s = {2'b00, px[15:11]} + {2'b00, px[10:6]} + {2'b00, px[10:6]} + {2'b00, px[4:0]};
        y5_s  = sum_s[6:2];
        return {y5_s[4:1], y5_s[4:1], y5_s[4:1]};
    endfunction

endpackage

// File: rtl/camera_pixel_fmt.sv
// Combinational RGB565 to 12-bit frame-buffer format conversion (RGB444 or grey444).
module camera_pixel_fmt
    import camera_pkg::*;
(
    input  logic [15:0] pixel,
    input  logic        mode,
    output logic [11:0] pix_out
);

    // Select the output format for the assembled pixel
    always_comb begin
        if (mode == MODE_GREY) begin
            pix_out = rgb565_to_grey(pixel);
        end else begin
            pix_out = rgb565_to_444(pixel);
        end
    end

endmodule

// File: rtl/camera_capture_ctrl.sv
// DVP capture controller: frame arming FSM, byte-pair assembly, decimation and frame-buffer writes.
// Optional window cropping is enabled by defining CAMERA_CROP_EN.
module camera_capture_ctrl
    import camera_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DECIM    = 2,
    parameter int ADDR_W   = 17,
    parameter int FCNT_W   = 8,
`ifdef CAMERA_CROP_EN
    parameter int CROP_W   = 320,
    parameter int CROP_H   = 240,
    parameter int MAX_PIX  = CROP_W * CROP_H
`else
    parameter int MAX_PIX  = (H_ACTIVE / DECIM) * (V_ACTIVE / DECIM)
`endif
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d_data,
    input  logic              capture_en,
    input  logic              single_shot,
    input  logic              mode,
`ifdef CAMERA_CROP_EN
    input  logic [10:0]       crop_x,
    input  logic [9:0]        crop_y,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              overflow,
    output logic              busy
);

    localparam int COL_W  = 11;
    localparam int ROW_W  = 10;
    localparam int DEC_SH = (DECIM >= 4) ? 2 : ((DECIM >= 2) ? 1 : 0);
    localparam logic [COL_W-1:0] COL_MASK  = COL_W'(DECIM - 1);
    localparam logic [ROW_W-1:0] ROW_MASK  = ROW_W'(DECIM - 1);
    localparam logic [COL_W-1:0] H_LIM     = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] V_LIM     = ROW_W'(V_ACTIVE);
    localparam logic [ADDR_W:0]  MAX_PIX_V = (ADDR_W + 1)'(MAX_PIX);

    cam_state_e        state_r, next_s;
    logic              vs_prev_r, href_prev_r, phase_r, armed_r, mode_r;
    logic [7:0]        hi_r;
    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wr_en_r, frame_done_r, overflow_r, busy_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [11:0]       wr_data_r;
    logic [FCNT_W-1:0] frame_cnt_r;
    logic              vs_fall_s, vs_rise_s, start_s, byte_s, lo_s, line_end_s;
    logic              keep_s, full_s, crop_ok_s;
    logic [11:0]       fmt_s;

    assign vs_fall_s  = vs_prev_r & ~vsync;
    assign vs_rise_s  = ~vs_prev_r & vsync;
    assign start_s    = (state_r == WAIT_VS) && (next_s == ACTIVE);
    // Bytes only count while the frame is open; vsync high discards a half-assembled pixel
    assign byte_s     = (state_r == ACTIVE) && href && !vsync;
    assign lo_s       = byte_s && phase_r;
    assign line_end_s = (state_r == ACTIVE) && href_prev_r && !href;
    assign full_s     = ({1'b0, addr_r} >= MAX_PIX_V);
    assign keep_s     = lo_s && (col_r < H_LIM) && (row_r < V_LIM)
                        && ((col_r & COL_MASK) == {COL_W{1'b0}})
                        && ((row_r & ROW_MASK) == {ROW_W{1'b0}}) && crop_ok_s;

`ifdef CAMERA_CROP_EN
    logic [COL_W-1:0] cx_r;
    logic [ROW_W-1:0] cy_r;
    logic [COL_W:0]   col_d_s;
    logic [ROW_W:0]   row_d_s;

    assign col_d_s   = {1'b0, col_r >> DEC_SH};
    assign row_d_s   = {1'b0, row_r >> DEC_SH};
    assign crop_ok_s = (col_d_s >= {1'b0, cx_r}) && (col_d_s < ({1'b0, cx_r} + (COL_W + 1)'(CROP_W)))
                       && (row_d_s >= {1'b0, cy_r}) && (row_d_s < ({1'b0, cy_r} + (ROW_W + 1)'(CROP_H)));

    // Window origin is frozen for the whole frame at ACTIVE entry
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            cx_r <= {COL_W{1'b0}};
            cy_r <= {ROW_W{1'b0}};
        end else if (start_s) begin
            cx_r <= crop_x;
            cy_r <= crop_y;
        end
    end
`else
    assign crop_ok_s = 1'b1;
`endif

    camera_pixel_fmt u_fmt (
        .pixel   ({hi_r, d_data}),
        .mode    (mode_r),
        .pix_out (fmt_s)
    );

    // FSM state register
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; an unarmed wait is abandoned once capture_en drops
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (capture_en || single_shot) next_s = WAIT_VS;
                else                           next_s = IDLE;
            end
            WAIT_VS: begin
                if (vs_fall_s)                                      next_s = ACTIVE;
                else if (!capture_en && !armed_r && !single_shot)   next_s = IDLE;
                else                                                next_s = WAIT_VS;
            end
            ACTIVE: begin
                if (vs_rise_s) next_s = DONE;
                else           next_s = ACTIVE;
            end
            DONE: begin
                if (capture_en && !armed_r) next_s = WAIT_VS;
                else                        next_s = IDLE;
            end
            default: next_s = IDLE;
        endcase
    end

    // Sync edge history, single-shot arming and per-frame mode latch
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            vs_prev_r   <= 1'b0;
            href_prev_r <= 1'b0;
            armed_r     <= 1'b0;
            mode_r      <= MODE_RGB444;
        end else begin
            vs_prev_r   <= vsync;
            href_prev_r <= href;
            if (state_r == DONE) begin
                armed_r <= 1'b0;
            end else if (single_shot && ((state_r == IDLE) || (state_r == WAIT_VS))) begin
                armed_r <= 1'b1;
            end
            if (start_s) begin
                mode_r <= mode;
            end
        end
    end

    // Byte phase, pixel position and write address; counters saturate past the active area
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            phase_r <= 1'b0;
            hi_r    <= 8'h00;
            col_r   <= {COL_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
        end else if (start_s) begin
            phase_r <= 1'b0;
            col_r   <= {COL_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
        end else begin
            phase_r <= byte_s ? ~phase_r : 1'b0;
            if (byte_s && !phase_r) begin
                hi_r <= d_data;
            end
            if (line_end_s) begin
                col_r <= {COL_W{1'b0}};
                if (row_r < V_LIM) row_r <= row_r + ROW_W'(1);
            end else if (lo_s && (col_r < H_LIM)) begin
                col_r <= col_r + COL_W'(1);
            end
            if (keep_s && !full_s) begin
                addr_r <= addr_r + ADDR_W'(1);
            end
        end
    end

    // Registered frame-buffer strobe and status outputs
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {ADDR_W{1'b0}};
            wr_data_r    <= 12'h000;
            frame_done_r <= 1'b0;
            frame_cnt_r  <= {FCNT_W{1'b0}};
            overflow_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            wr_en_r <= keep_s && !full_s;
            if (keep_s && !full_s) begin
                wr_addr_r <= addr_r;
                wr_data_r <= fmt_s;
            end
            if (keep_s && full_s) begin
                overflow_r <= 1'b1;
            end
            frame_done_r <= (next_s == DONE);
            if (next_s == DONE) begin
                frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
            end
            busy_r <= (next_s == ACTIVE);
        end
    end

    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign frame_done = frame_done_r;
    assign frame_cnt  = frame_cnt_r;
    assign overflow   = overflow_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Scoreboard bench: three controller instances (DECIM 1, DECIM 2, DECIM 2 with a reduced pixel limit)
// share one randomized sensor stream; a behavioural model predicts every write.
module tb_camera_capture_ctrl;
    localparam int H = 8;
    localparam int V = 4;

    typedef struct packed {
        logic [16:0] addr;
        logic [11:0] data;
    } wr_t;

    logic       pclk = 1'b0;
    logic       reset, vsync, href, capture_en, single_shot, mode;
    logic [7:0] d_data;

    logic        wr_en[3];
    logic [16:0] wr_addr[3];
    logic [11:0] wr_data[3];
    logic        frame_done[3];
    logic [7:0]  frame_cnt[3];
    logic        overflow[3];
    logic        busy[3];

    int tests = 0;
    int fails = 0;
    bit sb_off = 1'b0;
    wr_t q0[$], q1[$], q2[$];
    int m_addr[3], m_fcnt[3], done_cnt[3], done_base[3];
    bit m_ovf[3];
    int decim[3]  = '{1, 2, 2};
    int maxpix[3] = '{32, 8, 7};

    always #5 pclk = ~pclk;

    camera_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .ADDR_W(17), .FCNT_W(8)) dut_a (
        .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .d_data(d_data),
        .capture_en(capture_en), .single_shot(single_shot), .mode(mode),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .frame_done(frame_done[0]),
        .frame_cnt(frame_cnt[0]), .overflow(overflow[0]), .busy(busy[0]));

    camera_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(2), .ADDR_W(17), .FCNT_W(8)) dut_b (
        .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .d_data(d_data),
        .capture_en(capture_en), .single_shot(single_shot), .mode(mode),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .frame_done(frame_done[1]),
        .frame_cnt(frame_cnt[1]), .overflow(overflow[1]), .busy(busy[1]));

    camera_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(2), .ADDR_W(17), .FCNT_W(8),
                          .MAX_PIX(7)) dut_c (
        .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .d_data(d_data),
        .capture_en(capture_en), .single_shot(single_shot), .mode(mode),
        .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]), .frame_done(frame_done[2]),
        .frame_cnt(frame_cnt[2]), .overflow(overflow[2]), .busy(busy[2]));

    function automatic logic [11:0] ref_fmt(input logic [15:0] px, input logic m);
        int r5, g6, b5, y;
        logic [3:0] y4;
        r5 = int'(px[15:11]);
        g6 = int'(px[10:5]);
        b5 = int'(px[4:0]);
        if (m) begin
            y  = (r5 + g6 / 2 + g6 / 2 + b5) / 4;
            y4 = 4'(y / 2);
            return {y4, y4, y4};
        end
        return {4'(r5 / 2), 4'(g6 / 4), 4'(b5 / 2)};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int d, input wr_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int q_size(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic check_wr(input int d, input logic [16:0] a, input logic [11:0] dat);
        wr_t e;
        tests++;
        if (q_size(d) == 0) begin
            fails++;
            $display("FAIL wr_unexpected dut%0d: got addr %0d data %h, expected no write", d, a, dat);
        end else begin
            case (d)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            if (e.addr !== a || e.data !== dat) begin
                fails++;
                $display("FAIL wr_data dut%0d: got addr %0d data %h, expected addr %0d data %h",
                         d, a, dat, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every write strobe is popped against the scoreboard
    always @(negedge pclk) begin
        if (reset && !sb_off) begin
            for (int d = 0; d < 3; d++) begin
                if (wr_en[d]) check_wr(d, wr_addr[d], wr_data[d]);
                if (frame_done[d]) done_cnt[d]++;
            end
        end
    end

    task automatic model_pixel(input int r, input int c, input logic [15:0] px, input logic m);
        wr_t e;
        for (int d = 0; d < 3; d++) begin
            if (r < V && c < H && (c % decim[d]) == 0 && (r % decim[d]) == 0) begin
                if (m_addr[d] < maxpix[d]) begin
                    e.addr = 17'(m_addr[d]);
                    e.data = ref_fmt(px, m);
                    push_exp(d, e);
                    m_addr[d]++;
                end else begin
                    m_ovf[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic run_frame(input int nlines, input int npix, input bit cap, input bit fixed, input bit flip);
        logic [15:0] px;
        logic fmode;
        vsync = 1'b1;
        href  = 1'b0;
        repeat (4) @(negedge pclk);
        vsync = 1'b0;
        fmode = mode;
        if (cap) for (int d = 0; d < 3; d++) m_addr[d] = 0;
        repeat (2) @(negedge pclk);
        for (int d = 0; d < 3; d++) chk($sformatf("busy_in_frame dut%0d", d), 64'(busy[d]), 64'(cap));
        for (int r = 0; r < nlines; r++) begin
            for (int c = 0; c < npix; c++) begin
                px = 16'($urandom);
                if (fixed && r == 0 && c == 0) px = 16'hFFFF;
                if (fixed && r == 0 && c == 1) px = 16'hF800;
                if (cap) model_pixel(r, c, px, fmode);
                href   = 1'b1;
                d_data = px[15:8];
                @(negedge pclk);
                d_data = px[7:0];
                @(negedge pclk);
            end
            href   = 1'b0;
            d_data = 8'($urandom);
            if (flip && r == 0) mode = ~mode;
            repeat (3) @(negedge pclk);
        end
        vsync = 1'b1;
        repeat (5) @(negedge pclk);
        if (cap) for (int d = 0; d < 3; d++) m_fcnt[d]++;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("pending_writes dut%0d", d), 64'(q_size(d)), 64'd0);
            chk($sformatf("frame_cnt dut%0d", d), 64'(frame_cnt[d]), 64'(m_fcnt[d] % 256));
            chk($sformatf("frame_done_pulses dut%0d", d), 64'(done_cnt[d] - done_base[d]), 64'(m_fcnt[d]));
            chk($sformatf("overflow dut%0d", d), 64'(overflow[d]), 64'(m_ovf[d]));
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        for (int d = 0; d < 3; d++)
            chk($sformatf("%s dut%0d", name, d),
                64'({wr_en[d], wr_addr[d], wr_data[d], frame_done[d], frame_cnt[d], overflow[d], busy[d]}),
                64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; vsync = 1'b1; href = 1'b0; d_data = 8'h00;
        capture_en = 1'b0; single_shot = 1'b0; mode = 1'b0;
        for (int d = 0; d < 3; d++) begin
            m_addr[d] = 0; m_fcnt[d] = 0; m_ovf[d] = 1'b0; done_cnt[d] = 0; done_base[d] = 0;
        end
        repeat (3) @(negedge pclk);
        chk_outputs_zero("reset_state");
        reset = 1'b1;
        capture_en = 1'b1;
        repeat (2) @(negedge pclk);

        run_frame(4, 8, 1'b1, 1'b0, 1'b0);
        mode = 1'b1;
        run_frame(4, 8, 1'b1, 1'b1, 1'b0);
        mode = 1'b0;
        run_frame(4, 8, 1'b1, 1'b1, 1'b1);
        run_frame(5, 9, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mode = 1'($urandom);
            run_frame(4 + int'($urandom_range(0, 1)), 8 + int'($urandom_range(0, 2)), 1'b1, 1'b0, 1'b0);
        end

        capture_en = 1'b0;
        repeat (4) @(negedge pclk);
        single_shot = 1'b1;
        @(negedge pclk);
        single_shot = 1'b0;
        run_frame(4, 8, 1'b1, 1'b0, 1'b0);
        run_frame(4, 8, 1'b0, 1'b0, 1'b0);
        run_frame(4, 8, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) chk($sformatf("idle_after_single dut%0d", d), 64'(busy[d]), 64'd0);

        capture_en = 1'b1;
        sb_off = 1'b1;
        repeat (4) @(negedge pclk);
        vsync = 1'b0;
        repeat (3) @(negedge pclk);
        href = 1'b1;
        repeat (7) begin
            d_data = 8'($urandom);
            @(negedge pclk);
        end
        #2 reset = 1'b0;
        #1 chk_outputs_zero("async_reset");
        @(negedge pclk);
        href = 1'b0;
        vsync = 1'b1;
        for (int d = 0; d < 3; d++) begin
            m_addr[d] = 0; m_fcnt[d] = 0; m_ovf[d] = 1'b0; done_base[d] = done_cnt[d];
        end
        q0.delete(); q1.delete(); q2.delete();
        sb_off = 1'b0;
        repeat (2) @(negedge pclk);
        reset = 1'b1;
        mode = 1'b1;
        run_frame(4, 8, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
